// File: rtl/regfile_dump_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_dump_pkg;

  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned DW_DEF    = 64;
  localparam int unsigned ZERO_REG  = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks every register through one regfile read port and streams
// {index, value} beats out over a valid/ready handshake.
module regfile_dumper
  import regfile_dump_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ra,
  input  logic [DW-1:0] rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  dump_state_t   state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic          out_valid_nx;
  logic [AW-1:0] out_idx_nx;
  logic [DW-1:0] out_data_nx;

  // Next-state and holding-register update
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    out_valid_nx = out_valid;
    out_idx_nx   = out_idx;
    out_data_nx  = out_data;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = READ;
          idx_nx   = '0;
        end
      end
      READ: begin
        out_data_nx  = rd;
        out_idx_nx   = idx;
        out_valid_nx = 1'b1;
        state_nx     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_nx = 1'b0;
          if (idx == LAST_IDX) begin
            state_nx = DONE;
          end else begin
            idx_nx   = idx + AW'(1);
            state_nx = READ;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // ra leads into READ so the combinational regfile port settles within that cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ra        <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      busy      <= (state_nx != IDLE);
      done      <= (state_nx == DONE);
      ra        <= (state_nx == READ) ? idx_nx : '0;
      out_valid <= out_valid_nx;
      out_idx   <= out_idx_nx;
      out_data  <= out_data_nx;
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper against a behavioural regfile.
module tb_regfile_dumper;
  import regfile_dump_pkg::*;

  localparam int unsigned NR = NREGS_DEF;
  localparam int unsigned DWT = DW_DEF;
  localparam int unsigned AWT = $clog2(NR);

  typedef struct packed {
    logic [AWT-1:0] idx;
    logic [DWT-1:0] data;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           busy, done, out_valid;
  logic           out_ready = 1'b1;
  logic [AWT-1:0] ra, out_idx;
  logic [DWT-1:0] rd, out_data;

  // Regfile stand-in: combinational read, X31 hardwired to zero
  logic           we3 = 1'b0;
  logic [AWT-1:0] wa3 = '0;
  logic [DWT-1:0] wd3 = '0;
  logic           preload = 1'b1;
  logic [DWT-1:0] rf [NR];
  logic [DWT-1:0] shadow [NR];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(NR); i++) rf[i] <= DWT'(i);
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
  end
  assign rd = (ra == AWT'(ZERO_REG)) ? '0 : rf[ra];

  regfile_dumper dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .ra(ra), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int    chk_cnt = 0;
  int    pass_cnt = 0;
  int    edge_cnt = 0;
  int    accept_edge = 0;
  int    done_cnt = 0;
  int    beat_cnt = 0;
  bit    chk_timing = 1'b0;
  beat_t sb[$];

  task automatic chk(input string name, input logic [DWT-1:0] act, input logic [DWT-1:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  always @(posedge clk) edge_cnt++;

  // Monitor: compare each handshaken beat against the scoreboard, and check holds
  bit    holding = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (out_valid) begin
      if (holding) begin
        chk("hold_idx", DWT'(out_idx), DWT'(held.idx));
        chk("hold_data", out_data, held.data);
      end
      if (out_ready) begin
        beat_t e;
        holding = 1'b0;
        beat_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_beat", DWT'(out_idx), '1);
        end else begin
          e = sb.pop_front();
          chk("beat_idx", DWT'(out_idx), DWT'(e.idx));
          chk("beat_data", out_data, e.data);
        end
      end else begin
        holding   = 1'b1;
        held.idx  = out_idx;
        held.data = out_data;
      end
    end else begin
      holding = 1'b0;
    end
    if (done) begin
      done_cnt++;
      if (chk_timing) chk("done_latency", DWT'(edge_cnt - accept_edge), DWT'(64));
    end
  end

  // Reference: each register's value as the bench last wrote it, X31 always zero
  task automatic start_dump();
    @(posedge clk); #1;
    start = 1'b1;
    accept_edge = edge_cnt + 1;
    for (int i = 0; i < int'(NR); i++)
      sb.push_back('{idx: AWT'(i), data: (i == int'(ZERO_REG)) ? '0 : shadow[i]});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wr(input int a, input logic [DWT-1:0] v);
    @(posedge clk); #1;
    we3 = 1'b1; wa3 = AWT'(a); wd3 = v;
    shadow[a] = v;
    @(posedge clk); #1;
    we3 = 1'b0;
  endtask

  task automatic wait_beat(input int i);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (out_valid && out_idx == AWT'(i)) return;
    end
    chk("wait_beat_timeout", DWT'(i), '1);
  endtask

  task automatic wait_done(input int base_done, input int base_beats, input bit rand_ready);
    for (int c = 0; c < 1000 && done_cnt == base_done; c++) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", DWT'(done_cnt - base_done), DWT'(1));
    chk("beat_count", DWT'(beat_cnt - base_beats), DWT'(NR));
    chk("sb_empty", DWT'(sb.size()), '0);
    chk("idle_busy", DWT'(busy), '0);
  endtask

  int bd, bb;
  initial begin
    for (int i = 0; i < int'(NR); i++) shadow[i] = DWT'(i);
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    reset = 1'b1;
    chk("rst_busy", DWT'(busy), '0);
    chk("rst_done", DWT'(done), '0);
    chk("rst_valid", DWT'(out_valid), '0);
    chk("rst_idx", DWT'(out_idx), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ra", DWT'(ra), '0);

    // Full dump, ready held high, done latency checked
    bd = done_cnt; bb = beat_cnt;
    chk_timing = 1'b1;
    start_dump();
    chk("busy_after_start", DWT'(busy), DWT'(1));
    wait_done(bd, bb, 1'b0);
    chk_timing = 1'b0;

    // Prior write, backpressure, ignored restart, late write
    wr(1, 64'hc0cac01a);
    bd = done_cnt; bb = beat_cnt;
    start_dump();
    wait_beat(5);
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_valid", DWT'(out_valid), DWT'(1));
    chk("bp_idx", DWT'(out_idx), DWT'(5));
    out_ready = 1'b1;
    wait_beat(7);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_beat(25);
    we3 = 1'b1; wa3 = AWT'(20); wd3 = 64'haaaaaaaa;
    shadow[20] = 64'haaaaaaaa;
    @(posedge clk); #1;
    we3 = 1'b0;
    wait_done(bd, bb, 1'b0);

    // Reset mid-dump aborts with no done pulse
    bd = done_cnt;
    start_dump();
    wait_beat(10);
    reset = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", DWT'(busy), '0);
    chk("abort_valid", DWT'(out_valid), '0);
    chk("abort_done", DWT'(done), '0);
    reset = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("abort_no_done", DWT'(done_cnt - bd), '0);
    bd = done_cnt; bb = beat_cnt;
    start_dump();
    wait_done(bd, bb, 1'b0);

    // Random register contents with random backpressure
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < int'(NR) - 1; i++) wr(i, {$urandom, $urandom});
      bd = done_cnt; bb = beat_cnt;
      start_dump();
      wait_done(bd, bb, 1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
